// File: rtl/commu_m_srcsel.sv
// Frame-aligned read source selector: routes downstream reads to one of NCH sources or, when
// built with COMMU_M_SRCSEL_TPGEN_EN, to an internal test-pattern generator.
module commu_m_srcsel #(
    parameter int unsigned DW        = 8,
    parameter int unsigned NCH       = 4,
    parameter int unsigned FRAME_LEN = 256
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    output logic [NCH-1:0]         src_rd,
    input  logic [NCH*DW-1:0]      src_q,
    input  logic                   req_rd,
    output logic [DW-1:0]          req_q,
    output logic                   req_vld,
    input  logic [$clog2(NCH)-1:0] cfg_sel,
    input  logic [7:0]             cfg_tp,
    output logic [$clog2(NCH):0]   sel_cur
);

    localparam int unsigned SW = $clog2(NCH);
    localparam int unsigned FW = $clog2(FRAME_LEN);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [SW-1:0] ch_q, ch_d;
    logic          tp_q, tp_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s1_tp_q, s1_tp_d;
    logic [SW-1:0] s1_ch_q, s1_ch_d;
    logic [DW-1:0] s1_pat_q, s1_pat_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          vld_q, vld_d;

    logic          fstart;
    logic [SW-1:0] cfg_ch;
    logic [SW-1:0] eff_ch;
    logic          eff_tp;
    logic          cfg_tp_en;
    logic [DW-1:0] cur_pat;
    logic [DW-1:0] src_sel;

`ifdef COMMU_M_SRCSEL_TPGEN_EN
    localparam logic [2*DW-1:0] AltRep = {DW{2'b01}};
    localparam logic [DW-1:0]   Alt55  = AltRep[DW-1:0];

    logic [1:0]    pt_q, pt_d;
    logic [1:0]    eff_pt;
    logic [DW-1:0] pat_q, pat_d;
    logic [DW-1:0] pat_base;
    logic [DW-1:0] pat_nxt;
    logic [DW-1:0] fmark;
    logic          unused_cfg_tp;

    assign unused_cfg_tp = ^cfg_tp[6:2];

    always_comb begin
        cfg_tp_en = cfg_tp[7];
        eff_pt    = fstart ? cfg_tp[1:0] : pt_q;
        pt_d      = eff_pt;
        fmark     = DW'(fcnt_q & FW'(8'hFF));
        pat_base  = pat_q;
        // Frame start substitutes the reload value so it applies to that same read.
        if (fstart) begin
            case (eff_pt)
                2'b10:   pat_base = Alt55;
                2'b11:   pat_base = DW'(1);
                default: pat_base = '0;
            endcase
        end
        cur_pat = (eff_pt == 2'b01) ? fmark : pat_base;
        case (eff_pt)
            2'b00:   pat_nxt = cur_pat + DW'(1);
            2'b10:   pat_nxt = ~cur_pat;
            2'b11:   pat_nxt = {cur_pat[DW-2:0], cur_pat[DW-1]};
            default: pat_nxt = cur_pat;
        endcase
        pat_d = (req_rd && eff_tp) ? pat_nxt : pat_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pt_q  <= 2'b00;
            pat_q <= '0;
        end else begin
            pt_q  <= pt_d;
            pat_q <= pat_d;
        end
    end
`else
    logic unused_cfg_tp;

    assign unused_cfg_tp = ^cfg_tp;
    assign cfg_tp_en     = 1'b0;
    assign cur_pat       = '0;
`endif

    always_comb begin
        fstart = req_rd && (fcnt_q == '0);
        cfg_ch = (32'(cfg_sel) < NCH) ? cfg_sel : '0;
        eff_ch = fstart ? cfg_ch : ch_q;
        eff_tp = fstart ? cfg_tp_en : tp_q;
        fcnt_d = req_rd ? fcnt_q + FW'(1) : fcnt_q;
        ch_d   = eff_ch;
        tp_d   = eff_tp;

        // Selection travels with the read so a frame-boundary switch never mixes sources.
        s1_vld_d = req_rd;
        s1_tp_d  = eff_tp;
        s1_ch_d  = eff_ch;
        s1_pat_d = cur_pat;

        src_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s1_ch_q == SW'(k)) src_sel = src_q[k*DW +: DW];
        end
        vld_d   = s1_vld_q;
        rdata_d = rdata_q;
        if (s1_vld_q) rdata_d = s1_tp_q ? s1_pat_q : src_sel;
    end

    always_comb begin
        src_rd = '0;
        for (int k = 0; k < NCH; k++) begin
            src_rd[k] = rst_n && req_rd && !eff_tp && (eff_ch == SW'(k));
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q   <= '0;
            ch_q     <= '0;
            tp_q     <= 1'b0;
            s1_vld_q <= 1'b0;
            s1_tp_q  <= 1'b0;
            s1_ch_q  <= '0;
            s1_pat_q <= '0;
            rdata_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            fcnt_q   <= fcnt_d;
            ch_q     <= ch_d;
            tp_q     <= tp_d;
            s1_vld_q <= s1_vld_d;
            s1_tp_q  <= s1_tp_d;
            s1_ch_q  <= s1_ch_d;
            s1_pat_q <= s1_pat_d;
            rdata_q  <= rdata_d;
            vld_q    <= vld_d;
        end
    end

    assign req_q   = rdata_q;
    assign req_vld = vld_q;
    assign sel_cur = {tp_q, ch_q};

endmodule

// File: tb/tb_commu_m_srcsel.sv
// Directed bench for commu_m_srcsel (DW=8, NCH=4, FRAME_LEN=8); exercises the test-pattern
// path when COMMU_M_SRCSEL_TPGEN_EN is defined, the real-source-only build otherwise.
module tb_commu_m_srcsel;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  src_rd;
    logic [31:0] src_q   = '0;
    logic        req_rd  = 1'b0;
    logic [7:0]  req_q;
    logic        req_vld;
    logic [1:0]  cfg_sel = 2'd0;
    logic [7:0]  cfg_tp  = 8'h00;
    logic [2:0]  sel_cur;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    logic        src_clr = 1'b1;
    int          src_cnt [4];
    logic [7:0]  cap_q [$];
    int          vld_cyc [$];
    int          rd_cyc [$];
    logic [7:0]  exp_q [$];
    logic [3:0]  src_seen = '0;

    commu_m_srcsel #(
        .DW        (8),
        .NCH       (4),
        .FRAME_LEN (8)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .src_rd  (src_rd),
        .src_q   (src_q),
        .req_rd  (req_rd),
        .req_q   (req_q),
        .req_vld (req_vld),
        .cfg_sel (cfg_sel),
        .cfg_tp  (cfg_tp),
        .sel_cur (sel_cur)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] src_data(int k, int n);
        return 8'((k ^ 2) << 6) ^ 8'(17 * (n + 1));
    endfunction

    // Source model: data valid the cycle after its strobe, garbage otherwise.
    always @(posedge clk_sys) begin
        for (int k = 0; k < 4; k++) begin
            if (src_clr) begin
                src_cnt[k] <= 0;
                src_q[k*8 +: 8] <= 8'hEE;
            end else if (src_rd[k]) begin
                src_cnt[k] <= src_cnt[k] + 1;
                src_q[k*8 +: 8] <= src_data(k, src_cnt[k]);
            end else begin
                src_q[k*8 +: 8] <= 8'hEE;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (req_vld) begin
            cap_q.push_back(req_q);
            vld_cyc.push_back(cyc);
        end
        if (req_rd) rd_cyc.push_back(cyc);
        src_seen = src_seen | src_rd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_caps();
        cap_q.delete();
        vld_cyc.delete();
        rd_cyc.delete();
        exp_q.delete();
        src_seen = '0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        src_clr = 1'b1;
        req_rd  = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n   = 1'b1;
        src_clr = 1'b0;
        clear_caps();
    endtask

    task automatic rd_burst(input int n);
        for (int i = 0; i < n; i++) begin
            req_rd = 1'b1;
            @(posedge clk_sys);
            #1;
        end
        req_rd = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_caps(input string tag);
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), cap_q[i], exp_q[i]);
            if (i < rd_cyc.size())
                check($sformatf("%s_lat%0d", tag, i), vld_cyc[i] - rd_cyc[i], 2);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_req_q", req_q, 8'h00);
        check("rst_req_vld", req_vld, 1'b0);
        check("rst_sel_cur", sel_cur, 3'b000);
        req_rd = 1'b1;
        #1;
        check("rst_src_rd", src_rd, 4'b0000);
        req_rd = 1'b0;
        do_reset();

        // Four reads from channel 2
        cfg_sel = 2'd2;
        rd_burst(4);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_caps("ch2");
        check("ch2_src_mask", src_seen, 4'b0100);
        check("ch2_sel_cur", sel_cur, 3'b010);
        check("ch2_hold_q", req_q, 8'h44);
        check("ch2_hold_vld", req_vld, 1'b0);

        // Selection change mid-frame takes effect only at the next frame start
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cfg_sel = (i >= 5) ? 2'd3 : 2'd0;
            req_rd  = 1'b1;
            @(posedge clk_sys);
            #1;
            if (i == 7) check("frm_sel_before", sel_cur, 3'b000);
            if (i == 8) check("frm_sel_after", sel_cur, 3'b011);
        end
        req_rd = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        exp_q = '{8'h91, 8'hA2, 8'hB3, 8'hC4, 8'hD5, 8'hE6, 8'hF7, 8'h08, 8'h51};
        check_caps("frm");
        check("frm_src_mask", src_seen, 4'b1001);

`ifdef COMMU_M_SRCSEL_TPGEN_EN
        do_reset();
        cfg_sel = 2'd0;
        cfg_tp  = 8'h80;
        rd_burst(10);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};
        check_caps("tp_inc");
        check("tp_inc_src_mask", src_seen, 4'b0000);
        check("tp_inc_sel_cur", sel_cur, 3'b100);

        do_reset();
        cfg_tp = 8'h82;
        rd_burst(4);
        exp_q = '{8'h55, 8'hAA, 8'h55, 8'hAA};
        check_caps("tp_alt");

        do_reset();
        cfg_tp = 8'h83;
        rd_burst(4);
        exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
        check_caps("tp_walk");

        do_reset();
        cfg_tp = 8'h81;
        rd_burst(3);
        exp_q = '{8'h00, 8'h01, 8'h02};
        check_caps("tp_mark");
        cfg_tp = 8'h00;
`else
        do_reset();
        cfg_sel = 2'd1;
        cfg_tp  = 8'h80;
        rd_burst(2);
        exp_q = '{8'hD1, 8'hE2};
        check_caps("notp");
        check("notp_src_mask", src_seen, 4'b0010);
        check("notp_sel_cur", sel_cur, 3'b001);
        cfg_tp = 8'h00;
`endif

        // Reset with reads in flight
        do_reset();
        cfg_sel = 2'd2;
        req_rd  = 1'b1;
        @(posedge clk_sys);
        #3;
        rst_n   = 1'b0;
        src_clr = 1'b1;
        #1;
        check("inrst_src_rd", src_rd, 4'b0000);
        @(posedge clk_sys);
        #1;
        req_rd = 1'b0;
        @(posedge clk_sys);
        #1;
        rst_n   = 1'b1;
        src_clr = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("inrst_no_vld", cap_q.size(), 0);
        check("inrst_req_q", req_q, 8'h00);
        clear_caps();
        cfg_sel = 2'd1;
        rd_burst(1);
        exp_q = '{8'hD1};
        check_caps("postrst");
        check("postrst_sel_cur", sel_cur, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/commu_m_srcsel.md
COMMU_M_SRCSEL -- requirements
Module: commu_m_srcsel

Interface
REQ-001 Parameter DW, default 8: data width of every source and of req_q.
REQ-002 Parameter NCH, default 4: number of real source channels, 2..16.
REQ-003 Parameter FRAME_LEN, default 256: reads per frame, power of two, 2..65536.
REQ-004 Port clk_sys, input, 1: system clock; single clock domain.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port src_rd, output, NCH: per-channel read strobe.
REQ-007 Port src_q, input, NCH*DW: channel k data on bits [k*DW +: DW], valid one cycle after src_rd[k].
REQ-008 Port req_rd, input, 1: downstream read request, single-cycle pulse per byte.
REQ-009 Port req_q, output, DW: registered read data.
REQ-010 Port req_vld, output, 1: one-cycle qualifier for req_q.
REQ-011 Port cfg_sel, input, clog2(NCH): requested source channel.
REQ-012 Port cfg_tp, input, 8: bit7 test-pattern mode enable; bits[1:0] pattern type; other bits reserved and ignored.
REQ-013 Port sel_cur, output, clog2(NCH)+1: active selection; MSB set means test-pattern mode, LSBs give the channel.

Function
REQ-014 Frame counter fcnt (clog2(FRAME_LEN) bits) increments on each req_rd and wraps from FRAME_LEN-1 to 0.
REQ-015 Active selection (channel, tp mode, pattern type) latches from cfg_sel/cfg_tp only on a req_rd with fcnt==0; changes at any other time are ignored until the next frame start.
REQ-016 On a req_rd with fcnt==0, the new selection applies to that same read.
REQ-017 In real mode, src_rd[sel] equals req_rd combinationally and all other src_rd bits stay 0; in tp mode, all src_rd bits stay 0.
REQ-018 Latency: req_rd at cycle n drives req_q and req_vld=1 at cycle n+2 (one source stage, one output register), in both modes.
REQ-019 The pipeline carries the selection with each read, so a selection change at a frame boundary never mixes channels within one read.
REQ-020 Back-to-back req_rd every cycle is sustained with no bubbles.
REQ-021 Pattern type 00: incrementing byte, 0 at frame start, +1 per read, wraps modulo 2^DW.
REQ-022 Pattern type 01: constant {DW{1'b0}} with the LSB byte of fcnt (frame-position marker).
REQ-023 Pattern type 10: alternating 0x55/0xAA (replicated to DW), starting with 0x55 at frame start.
REQ-024 Pattern type 11: walking one, 1 at frame start, rotating left one bit per read.
REQ-025 Pattern state advances only on req_rd in tp mode and reloads at every frame start.
REQ-026 cfg_sel >= NCH selects channel 0.
REQ-027 req_q holds its last value when req_vld=0.

Reset
REQ-028 On rst_n low: src_rd=0, req_q=0, req_vld=0, sel_cur=0 (real mode, channel 0), fcnt=0, pattern state=0, and all pipeline stages cleared.
REQ-029 A reset during a frame discards in-flight reads; no req_vld is produced for reads issued before the reset.
REQ-030 After reset release, the first req_rd is a frame start.

Configuration
REQ-031 Macro COMMU_M_SRCSEL_TPGEN_EN: when defined, the test-pattern generator and tp mode are compiled in as specified above.
REQ-032 When COMMU_M_SRCSEL_TPGEN_EN is undefined: cfg_tp is ignored, the sel_cur MSB is tied to 0, and only real sources are used, with identical latency.

Verification
REQ-033 NCH=4, cfg_sel=2, 4 consecutive req_rd, src_q ch2 = 0x11,0x22,0x33,0x44 -> src_rd[2] only; req_q 0x11..0x44 with req_vld, 2 cycles after each req_rd.
REQ-034 FRAME_LEN=8: cfg_sel changes 0->3 at read 5 -> reads 5..7 still from ch0; read 8 (fcnt=0) from ch3; sel_cur updates on read 8.
REQ-035 cfg_tp=0x80, 10 continuous reads with FRAME_LEN=8 -> req_q 0,1,...,7,0,1; src_rd stays 0.
REQ-036 cfg_tp=0x82 and 0x83 over 4 reads -> 0x55,0xAA,0x55,0xAA and 0x01,0x02,0x04,0x08.
REQ-037 rst_n low for 1 cycle between two in-flight reads -> no req_vld for them; req_q=0; next read starts frame at fcnt=0.
REQ-038 Build without COMMU_M_SRCSEL_TPGEN_EN and cfg_tp=0x80, cfg_sel=1 -> data comes from ch1; sel_cur MSB = 0.
